// File: rtl/can_frame_stuffer.sv
// CAN frame serializer with bit stuffing: shifts a left-aligned frame out
// MSB-first, inserting a complement bit after every RUN_LEN equal bits.
module can_frame_stuffer #(
  parameter int MAX_LEN   = 98,
  parameter int RUN_LEN   = 5,
  parameter int BIT_TICKS = 1
) (
  input  logic                         clock_i,
  input  logic                         reset_ni,
  input  logic [MAX_LEN-1:0]           unstuffed_i,
  input  logic [$clog2(MAX_LEN+1)-1:0] len_i,
  input  logic                         start_i,
  output logic                         serial_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [$clog2(MAX_LEN):0]     stuff_count_o
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int CW = $clog2(MAX_LEN) + 1;

  localparam logic [LW-1:0] MAX_L     = LW'(MAX_LEN);
  localparam logic [7:0]    TICK_LAST = 8'(BIT_TICKS - 1);
  localparam logic [3:0]    RUN_MAX   = 4'(RUN_LEN);
  localparam logic [CW-1:0] CNT_SAT   = '1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t             state;
  logic [MAX_LEN-1:0] shreg;
  logic [LW-1:0]      remain;
  logic [7:0]         tick;
  logic [3:0]         run;
  logic               last_bit;

  logic [LW-1:0] eff_len;
  logic          bit_end;
  logic          nxt_bit;

  always_comb begin
    eff_len = (len_i > MAX_L) ? MAX_L : len_i;
    bit_end = (tick == TICK_LAST);
    nxt_bit = shreg[MAX_LEN-1];
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state         <= IDLE;
      serial_o      <= 1'b1;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      stuff_count_o <= '0;
      shreg         <= '0;
      remain        <= '0;
      tick          <= '0;
      run           <= '0;
      last_bit      <= 1'b1;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            stuff_count_o <= '0;
            tick          <= '0;
            if (eff_len == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
              run    <= '0;
            end else begin
              state    <= SEND;
              busy_o   <= 1'b1;
              serial_o <= unstuffed_i[MAX_LEN-1];
              last_bit <= unstuffed_i[MAX_LEN-1];
              run      <= 4'd1;
              shreg    <= unstuffed_i << 1;
              remain   <= eff_len - LW'(1);
            end
          end
        end
        SEND: begin
          if (!bit_end) begin
            tick <= tick + 8'd1;
          end else begin
            tick <= '0;
            // A full run forces a stuff bit before any further data,
            // including after the final data bit.
            if (run == RUN_MAX) begin
              serial_o <= ~last_bit;
              last_bit <= ~last_bit;
              run      <= 4'd1;
              if (stuff_count_o != CNT_SAT)
                stuff_count_o <= stuff_count_o + CW'(1);
            end else if (remain != '0) begin
              serial_o <= nxt_bit;
              last_bit <= nxt_bit;
              run      <= (nxt_bit == last_bit) ? run + 4'd1 : 4'd1;
              shreg    <= shreg << 1;
              remain   <= remain - LW'(1);
            end else begin
              state    <= DONE;
              busy_o   <= 1'b0;
              serial_o <= 1'b1;
              done_o   <= 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_can_frame_stuffer.sv
// Directed bench for can_frame_stuffer: stuffing patterns, bit timing,
// a full CAN frame, ignored starts, zero length, reset and back-to-back.
module tb_can_frame_stuffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [97:0] unstuffed = '0;
  logic [6:0]  len = '0;
  logic        start = 1'b0;
  logic        start4 = 1'b0;
  logic        serial, busy, done;
  logic [7:0]  stuff_cnt;
  logic        serial4, busy4, done4;
  logic [7:0]  stuff_cnt4;

  int checks = 0;
  int errors = 0;

  logic [255:0] cap;
  int           ncap;
  logic         gotdone;

  always #5 clk = ~clk;

  can_frame_stuffer dut (
    .clock_i      (clk),
    .reset_ni     (rst_n),
    .unstuffed_i  (unstuffed),
    .len_i        (len),
    .start_i      (start),
    .serial_o     (serial),
    .busy_o       (busy),
    .done_o       (done),
    .stuff_count_o(stuff_cnt)
  );

  can_frame_stuffer #(.BIT_TICKS(4)) dut4 (
    .clock_i      (clk),
    .reset_ni     (rst_n),
    .unstuffed_i  (unstuffed),
    .len_i        (len),
    .start_i      (start4),
    .serial_o     (serial4),
    .busy_o       (busy4),
    .done_o       (done4),
    .stuff_count_o(stuff_cnt4)
  );

  // Reference stuffer: emits the stuff bit right after the run closes.
  function automatic int stuff_model(input logic [97:0] v, input int l,
                                     output logic [255:0] o);
    int n = 0;
    int r = 0;
    logic p = 1'b0;
    o = '0;
    for (int i = 0; i < l; i++) begin
      logic b;
      b = v[97-i];
      if (r > 0 && b == p) r++;
      else r = 1;
      p = b;
      o[n] = b;
      n++;
      if (r == 5) begin
        o[n] = ~b;
        n++;
        p = ~b;
        r = 1;
      end
    end
    return n;
  endfunction

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [97:0] v, input logic [6:0] l);
    unstuffed = v;
    len = l;
    start = 1'b1;
    tick1();
    start = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 300 && (busy || done); c++) tick1();
    tick1();
  endtask

  task automatic capture(input int poke_at);
    ncap = 0;
    gotdone = 1'b0;
    cap = '0;
    for (int c = 0; c < 400; c++) begin
      if (!busy) begin
        gotdone = done;
        return;
      end
      cap[ncap] = serial;
      ncap++;
      if (c == poke_at) begin
        start = 1'b1;
        unstuffed = {98{1'b1}};
        len = 7'd20;
      end else begin
        start = 1'b0;
      end
      tick1();
    end
    checks++;
    errors++;
    $display("FAIL capture_timeout: busy stuck high after %0d bits", ncap);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    start4 = 1'b1;
    len = 7'd10;
    tick1();
    tick1();
    start = 1'b0;
    start4 = 1'b0;
    checks++;
    if ({serial, busy, done, stuff_cnt} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_state: got s=%b b=%b d=%b c=%0d want 1 0 0 0",
               serial, busy, done, stuff_cnt);
    end
    checks++;
    if ({serial4, busy4, done4} !== 3'b100) begin
      errors++;
      $display("FAIL reset_state4: got %b want 100", {serial4, busy4, done4});
    end
    rst_n = 1'b1;
    tick1();
  endtask

  task automatic test_all_zero();
    logic [11:0] got;
    launch({10'b0, {88{1'b1}}}, 7'd10);
    capture(-1);
    for (int i = 0; i < 12; i++) got[11-i] = cap[i];
    checks++;
    if (ncap !== 12 || got !== 12'b000001000001) begin
      errors++;
      $display("FAIL zero_stream: got %0d bits %b want 12 bits 000001000001",
               ncap, got);
    end
    checks++;
    if (gotdone !== 1'b1 || stuff_cnt !== 8'd2) begin
      errors++;
      $display("FAIL zero_done_count: got done=%b cnt=%0d want 1 2",
               gotdone, stuff_cnt);
    end
    tick1();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: got done=%b want 0", done);
    end
    tick1();
    tick1();
    checks++;
    if (stuff_cnt !== 8'd2 || serial !== 1'b1) begin
      errors++;
      $display("FAIL count_hold: got cnt=%0d s=%b want 2 1", stuff_cnt, serial);
    end
  endtask

  task automatic test_run_across_stuff();
    logic [11:0] got;
    launch({10'b1111100000, 88'b0}, 7'd10);
    capture(-1);
    for (int i = 0; i < 12; i++) got[11-i] = cap[i];
    checks++;
    if (ncap !== 12 || got !== 12'b111110000010) begin
      errors++;
      $display("FAIL run_stream: got %0d bits %b want 12 bits 111110000010",
               ncap, got);
    end
    checks++;
    if (stuff_cnt !== 8'd2) begin
      errors++;
      $display("FAIL run_count: got %0d want 2", stuff_cnt);
    end
    drain();
  endtask

  task automatic test_bit_ticks();
    logic [11:0] got;
    int n;
    logic gd;
    n = 0;
    gd = 1'b0;
    got = '0;
    unstuffed = {3'b101, 95'b0};
    len = 7'd3;
    start4 = 1'b1;
    tick1();
    start4 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!busy4) begin
        gd = done4;
        break;
      end
      if (n < 12) got[11-n] = serial4;
      n++;
      tick1();
    end
    checks++;
    if (n !== 12 || got !== 12'b111100001111) begin
      errors++;
      $display("FAIL ticks_stream: got %0d cycles %b want 12 111100001111",
               n, got);
    end
    checks++;
    if (gd !== 1'b1 || stuff_cnt4 !== 8'd0) begin
      errors++;
      $display("FAIL ticks_done: got done=%b cnt=%0d want 1 0", gd, stuff_cnt4);
    end
    tick1();
    tick1();
  endtask

  task automatic test_can_frame();
    logic [65:0]  frame;
    logic [255:0] gold;
    int           ng;
    int           bad;
    frame = {1'b0, 11'h123, 1'b0, 6'b000100, 32'hDEADBEEF, 15'h4E6B};
    ng = stuff_model({frame, 32'b0}, 66, gold);
    launch({frame, 32'b0}, 7'd66);
    capture(-1);
    bad = -1;
    for (int i = ng - 1; i >= 0; i--) if (cap[i] !== gold[i]) bad = i;
    checks++;
    if (ncap !== ng || bad != -1) begin
      errors++;
      $display("FAIL can_stream: got %0d bits want %0d, first bad bit %0d",
               ncap, ng, bad);
    end
    checks++;
    if (stuff_cnt !== 8'(ng - 66) || gotdone !== 1'b1) begin
      errors++;
      $display("FAIL can_count: got cnt=%0d done=%b want %0d 1",
               stuff_cnt, gotdone, ng - 66);
    end
    drain();
  endtask

  task automatic test_ignore_start();
    logic [11:0] got;
    launch({10'b0, 88'b0}, 7'd10);
    capture(3);
    start = 1'b0;
    for (int i = 0; i < 12; i++) got[11-i] = cap[i];
    checks++;
    if (ncap !== 12 || got !== 12'b000001000001 || stuff_cnt !== 8'd2) begin
      errors++;
      $display("FAIL ignore_start: got %0d bits %b cnt=%0d want 12 000001000001 2",
               ncap, got, stuff_cnt);
    end
    tick1();
    tick1();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_idle: got busy=%b want 0", busy);
    end
    launch({98{1'b0}}, 7'd0);
    checks++;
    if ({done, busy, serial, stuff_cnt} !== {3'b101, 8'd0}) begin
      errors++;
      $display("FAIL len0_done: got d=%b b=%b s=%b c=%0d want 1 0 1 0",
               done, busy, serial, stuff_cnt);
    end
    tick1();
    checks++;
    if ({done, busy, serial} !== 3'b001) begin
      errors++;
      $display("FAIL len0_after: got %b want 001", {done, busy, serial});
    end
    tick1();
  endtask

  task automatic test_reset_mid_frame();
    logic [11:0] got;
    int seen;
    launch({10'b0, 88'b0}, 7'd10);
    for (int c = 0; c < 5; c++) tick1();
    rst_n = 1'b0;
    tick1();
    rst_n = 1'b1;
    checks++;
    if ({serial, busy, done, stuff_cnt} !== {3'b100, 8'd0}) begin
      errors++;
      $display("FAIL reset_abort: got s=%b b=%b d=%b c=%0d want 1 0 0 0",
               serial, busy, done, stuff_cnt);
    end
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      if (done || busy || !serial) seen++;
      tick1();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_resume: got %0d active cycles want 0", seen);
    end
    launch({10'b1111100000, 88'b0}, 7'd10);
    capture(-1);
    for (int i = 0; i < 12; i++) got[11-i] = cap[i];
    checks++;
    if (ncap !== 12 || got !== 12'b111110000010 || gotdone !== 1'b1) begin
      errors++;
      $display("FAIL reset_next_frame: got %0d bits %b done=%b want 12 111110000010 1",
               ncap, got, gotdone);
    end
    drain();
  endtask

  task automatic test_clamp();
    launch({49{2'b10}}, 7'd120);
    capture(-1);
    checks++;
    if (ncap !== 98 || stuff_cnt !== 8'd0 || gotdone !== 1'b1) begin
      errors++;
      $display("FAIL clamp_len: got %0d bits cnt=%0d done=%b want 98 0 1",
               ncap, stuff_cnt, gotdone);
    end
    checks++;
    if (cap[0] !== 1'b1 || cap[97] !== 1'b0) begin
      errors++;
      $display("FAIL clamp_edges: got first=%b last=%b want 1 0",
               cap[0], cap[97]);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int c;
    unstuffed = {3'b101, 95'b0};
    len = 7'd3;
    start = 1'b1;
    tick1();
    for (c = 0; c < 20 && busy; c++) tick1();
    checks++;
    if (c !== 3 || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got %0d bits done=%b want 3 1", c, done);
    end
    tick1();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_gap: got busy/done %b want 00", {busy, done});
    end
    tick1();
    checks++;
    if ({busy, serial} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_restart: got busy/serial %b want 11", {busy, serial});
    end
    start = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_run_across_stuff();
    test_bit_ticks();
    test_can_frame();
    test_ignore_start();
    test_reset_mid_frame();
    test_clamp();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
